seg7_scan_driver: RTL and testbench

- Downstream consumer of the 2-bit refresh counter in the 7seg path. Turns the digit-select count into registered anode and segment drives for a 4-digit multiplexed hex display.
- Holds the displayed value in a tear-free shadow register that is only updated at frame boundaries.
- Inserts ghost-suppression blanking on every digit change and optionally suppresses leading zeros.

---
 rtl/seg7_pkg.sv | 34 +++
 rtl/hex_to_seg7.sv | 13 +
 rtl/seg7_scan_driver.sv | 136 +++++++++++++
 tb/tb_seg7_scan_driver.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared constants and helpers for the 7-segment display path.
// Segment patterns are active-low in {g,f,e,d,c,b,a} order.
package seg7_pkg;

    localparam logic [6:0] SEG_OFF = 7'h7F;
    localparam logic [3:0] AN_OFF  = 4'hF;

    localparam logic [6:0] HEX_SEG [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30,
        7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03,
        7'h46, 7'h21, 7'h06, 7'h0E
    };

    // Contents of one displayed frame: four hex nibbles plus per-digit dp.
    typedef struct packed {
        logic [15:0] value;
        logic [3:0]  dp;
    } disp_data_t;

    localparam disp_data_t DISP_RESET = '{value: 16'h0000, dp: 4'h0};

    // Bit i set when digit i is a leading zero (nibbles i..3 all zero).
    // Digit 0 is never flagged so a zero value still shows one digit.
    function automatic logic [3:0] lead_zero_mask(input logic [15:0] v);
        logic [3:0] mask;
        mask = 4'b0000;
        for (int i = 1; i < 4; i++) begin
            mask[i] = ((v >> (4 * i)) == 16'h0000);
        end
        return mask;
    endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational nibble to active-low 7-segment decoder.
module hex_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    always_comb begin
        seg = HEX_SEG[nibble];
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Registered anode/segment driver for a 4-digit multiplexed hex display with
// frame-aligned shadow updates, ghost blanking and leading-zero suppression.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int BLANK_CYCLES = 4,
    parameter int BLANK_W      = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  digit_sel,
    input  logic [15:0] value,
    input  logic [3:0]  dp_in,
    input  logic        load,
    input  logic        lz_en,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_sync,
    output logic        updated
);

    localparam logic [BLANK_W-1:0] BLANK_LOAD = BLANK_W'(BLANK_CYCLES);
    localparam logic [BLANK_W-1:0] BLANK_ONE  = BLANK_W'(1);

    logic [1:0]         sel_q, sel_d;
    disp_data_t         pend_q, pend_d;
    logic               pend_valid_q, pend_valid_d;
    disp_data_t         shadow_q, shadow_d;
    logic [BLANK_W-1:0] blank_q, blank_d;
    logic [3:0]         an_q, an_d;
    logic [6:0]         seg_q, seg_d;
    logic               dp_q, dp_d;
    logic               frame_sync_q, frame_sync_d;
    logic               updated_q, updated_d;

    logic               sel_change;
    logic               frame_edge;
    logic               commit;
    logic [3:0]         cur_nibble;
    logic [6:0]         dec_seg;
    logic [3:0]         lz_mask;
    logic               suppress;

    assign sel_change = (digit_sel != sel_q);
    assign frame_edge = (sel_q == 2'd3) && (digit_sel == 2'd0);
    assign commit     = frame_edge && pend_valid_q;

    // Pending/shadow pair: loads land in pending at any time, shadow only
    // moves at a frame edge so a frame never mixes old and new digits.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        sel_d        = digit_sel;
        pend_d       = pend_q;
        pend_valid_d = pend_valid_q;
        shadow_d     = shadow_q;
        frame_sync_d = frame_edge;
        updated_d    = commit;

        if (commit) begin
            shadow_d     = pend_q;
            pend_valid_d = 1'b0;
        end
        if (load) begin
            pend_d       = '{value: value, dp: dp_in};
            pend_valid_d = 1'b1;
        end
    end

    always_comb begin
        blank_d = blank_q;
        if (sel_change) begin
            blank_d = BLANK_LOAD;
        end else if (blank_q != '0) begin
            blank_d = blank_q - BLANK_ONE;
        end
    end

    // The drive is computed from the values the registers are about to take,
    // so a new frame shows the freshly committed shadow from its first digit.
    assign cur_nibble = shadow_d.value[{sel_d, 2'b00} +: 4];
    assign lz_mask    = lead_zero_mask(shadow_d.value);
    assign suppress   = lz_en && lz_mask[sel_d];

    hex_to_seg7 u_hex_to_seg7 (
        .nibble (cur_nibble),
        .seg    (dec_seg)
    );

    always_comb begin
        an_d  = AN_OFF;
        seg_d = SEG_OFF;
        dp_d  = 1'b1;
        if (blank_d == '0) begin
            an_d  = ~(4'b0001 << sel_d);
            seg_d = suppress ? SEG_OFF : dec_seg;
            dp_d  = ~shadow_d.dp[sel_d];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_q        <= 2'd0;
            pend_q       <= DISP_RESET;
            pend_valid_q <= 1'b0;
            shadow_q     <= DISP_RESET;
            blank_q      <= '0;
            an_q         <= AN_OFF;
            seg_q        <= SEG_OFF;
            dp_q         <= 1'b1;
            frame_sync_q <= 1'b0;
            updated_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge value of the others regardless of statement order.
            sel_q        <= sel_d;
            pend_q       <= pend_d;
            pend_valid_q <= pend_valid_d;
            shadow_q     <= shadow_d;
            blank_q      <= blank_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            frame_sync_q <= frame_sync_d;
            updated_q    <= updated_d;
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign dp         = dp_q;
    assign frame_sync = frame_sync_q;
    assign updated    = updated_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed plus randomized bench for seg7_scan_driver against a cycle-indexed
// behavioural model of the display rules.
module tb_seg7_scan_driver;

    localparam int BLANK = 4;

    localparam logic [6:0] REF_SEG [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    logic        clk;
    logic        rst_n;
    logic [1:0]  digit_sel;
    logic [15:0] value;
    logic [3:0]  dp_in;
    logic        load;
    logic        lz_en;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_sync;
    logic        updated;

    int total = 0;
    int bad   = 0;

    // Model state: last sampled digit, pending/shadow contents, and the last
    // cycle index whose outputs must be blank.
    int          cyc = 0;
    int          blank_last = -100;
    int          up_seen = 0;
    logic [1:0]  m_sel;
    logic [15:0] m_pv, m_sh;
    logic [3:0]  m_pd, m_shd;
    bit          m_pval;
    logic [3:0]  e_an;
    logic [6:0]  e_seg;
    logic        e_dp, e_fs, e_up;

    seg7_scan_driver #(.BLANK_CYCLES(BLANK), .BLANK_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .digit_sel  (digit_sel),
        .value      (value),
        .dp_in      (dp_in),
        .load       (load),
        .lz_en      (lz_en),
        .an         (an),
        .seg        (seg),
        .dp         (dp),
        .frame_sync (frame_sync),
        .updated    (updated)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_sel = 2'd0; m_pv = '0; m_pd = '0; m_pval = 0;
        m_sh = '0; m_shd = '0; blank_last = cyc;
    endtask

    task automatic check_off(input string tag);
        chk({tag, "_an"}, an, 4'hF);
        chk({tag, "_seg"}, seg, 7'h7F);
        chk({tag, "_dp"}, dp, 1'b1);
        chk({tag, "_fs"}, frame_sync, 1'b0);
        chk({tag, "_upd"}, updated, 1'b0);
    endtask

    // One clock: drive inputs, advance the model on the edge, compare 1ns later.
    task automatic tick(input logic [1:0] s, input logic ld, input logic [15:0] v,
                        input logic [3:0] d);
        bit boundary, commit, supp;
        logic [3:0] nib;
        digit_sel = s; load = ld; value = v; dp_in = d;
        @(posedge clk);
        cyc++;
        boundary = (m_sel == 2'd3) && (s == 2'd0);
        commit   = boundary && m_pval;
        if (commit) begin
            m_sh = m_pv; m_shd = m_pd;
        end
        if (ld) begin
            m_pv = v; m_pd = d; m_pval = 1;
        end else if (commit) begin
            m_pval = 0;
        end
        if (s != m_sel) blank_last = cyc + BLANK - 1;
        m_sel = s;
        e_fs = boundary;
        e_up = commit;
        if (cyc <= blank_last) begin
            e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
        end else begin
            e_an  = 4'hF ^ (4'h1 << s);
            nib   = 4'((m_sh >> (4 * s)) & 16'h000F);
            supp  = lz_en && (s != 2'd0) && ((m_sh >> (4 * s)) == 16'h0000);
            e_seg = supp ? 7'h7F : REF_SEG[nib];
            e_dp  = ~m_shd[s];
        end
        #1;
        if (updated === 1'b1) up_seen++;
        chk("an", an, e_an);
        chk("seg", seg, e_seg);
        chk("dp", dp, e_dp);
        chk("frame_sync", frame_sync, e_fs);
        chk("updated", updated, e_up);
    endtask

    // Hold a digit long enough to clear blanking, then check its segments.
    task automatic show(input logic [1:0] s, input logic [6:0] exp_seg, input string tag);
        for (int i = 0; i < BLANK + 2; i++) tick(s, 1'b0, 16'h0000, 4'h0);
        chk({tag, "_seg"}, seg, exp_seg);
        chk({tag, "_an"}, an, 4'hF ^ (4'h1 << s));
    endtask

    initial begin
        int up_before;
        logic [1:0] nxt;
        rst_n = 1'b0; digit_sel = 2'd0; value = '0; dp_in = '0; load = 1'b0; lz_en = 1'b0;
        model_reset();
        #12;
        check_off("rst_hold");
        @(negedge clk) rst_n = 1'b1;

        show(2'd0, 7'h40, "boot_d0");
        show(2'd1, 7'h40, "boot_d1");
        show(2'd2, 7'h40, "boot_d2");
        show(2'd3, 7'h40, "boot_d3");

        // Reset mid-frame with pending data: outputs go dark at once, data is lost.
        tick(2'd3, 1'b1, 16'hABCD, 4'hF);
        tick(2'd3, 1'b0, 16'h0000, 4'h0);
        #2 rst_n = 1'b0;
        #1 check_off("rst_mid");
        model_reset();
        @(negedge clk) rst_n = 1'b1;
        up_before = up_seen;
        show(2'd0, 7'h40, "post_rst_d0");
        show(2'd1, 7'h40, "post_rst_d1");
        show(2'd2, 7'h40, "post_rst_d2");
        show(2'd3, 7'h40, "post_rst_d3");
        show(2'd0, 7'h40, "discard_d0");
        chk("discard_no_upd", 16'(up_seen - up_before), 16'd0);

        // Load mid-frame: old value stays until the 3->0 edge.
        tick(2'd0, 1'b1, 16'h12AF, 4'b0101);
        show(2'd1, 7'h40, "hold_d1");
        show(2'd2, 7'h40, "hold_d2");
        show(2'd3, 7'h40, "hold_d3");
        up_before = up_seen;
        show(2'd0, 7'h0E, "new_d0");
        chk("commit_upd_once", 16'(up_seen - up_before), 16'd1);
        show(2'd1, 7'h08, "new_d1");
        show(2'd2, 7'h24, "new_d2");
        show(2'd3, 7'h79, "new_d3");

        // Load on the boundary cycle: old pending commits, new one waits a frame.
        tick(2'd3, 1'b1, 16'h1111, 4'h0);
        up_before = up_seen;
        tick(2'd0, 1'b1, 16'h2222, 4'h0);
        show(2'd0, 7'h79, "coll_d0");
        chk("coll_upd1", 16'(up_seen - up_before), 16'd1);
        show(2'd1, 7'h79, "coll_d1");
        show(2'd2, 7'h79, "coll_d2");
        show(2'd3, 7'h79, "coll_d3");
        show(2'd0, 7'h24, "coll2_d0");
        chk("coll_upd2", 16'(up_seen - up_before), 16'd2);
        show(2'd1, 7'h24, "coll2_d1");

        // Blank timing: change at N blanks N+1..N+4, digit at N+5.
        show(2'd0, 7'h24, "blk_pre");
        for (int t = 0; t < BLANK; t++) begin
            tick(2'd1, 1'b0, 16'h0000, 4'h0);
            chk("blank_win", an, 4'hF);
        end
        tick(2'd1, 1'b0, 16'h0000, 4'h0);
        chk("blank_end", an, 4'b1101);
        // Second change two cycles in extends blanking to N+6.
        tick(2'd2, 1'b0, 16'h0000, 4'h0);
        tick(2'd2, 1'b0, 16'h0000, 4'h0);
        for (int t = 0; t < BLANK; t++) begin
            tick(2'd3, 1'b0, 16'h0000, 4'h0);
            chk("blank_ext", an, 4'hF);
        end
        tick(2'd3, 1'b0, 16'h0000, 4'h0);
        chk("blank_ext_end", an, 4'b0111);

        // Leading-zero suppression on 0070.
        tick(2'd3, 1'b1, 16'h0070, 4'b1000);
        lz_en = 1'b1;
        show(2'd0, 7'h40, "lz_d0");
        show(2'd1, 7'h78, "lz_d1");
        show(2'd2, 7'h7F, "lz_d2");
        show(2'd3, 7'h7F, "lz_d3");
        chk("lz_d3_dp", dp, 1'b0);
        lz_en = 1'b0;
        show(2'd3, 7'h40, "nolz_d3");
        show(2'd2, 7'h40, "nolz_d2");

        // Non-boundary 3->1 jump: blank, no frame_sync, no commit.
        show(2'd3, 7'h40, "jump_pre");
        tick(2'd1, 1'b1, 16'hFFFF, 4'h0);
        chk("jump_blank", an, 4'hF);
        tick(2'd1, 1'b0, 16'h0000, 4'h0);
        chk("jump_no_fs", frame_sync, 1'b0);
        chk("jump_no_upd", updated, 1'b0);
        show(2'd1, 7'h78, "jump_d1");

        // Randomized scanning with sporadic loads, jumps and lz toggles.
        for (int i = 0; i < 800; i++) begin
            int r;
            r = int'($urandom_range(0, 9));
            if (r < 2)      nxt = 2'($urandom_range(0, 3));
            else if (r < 5) nxt = m_sel + 2'd1;
            else            nxt = m_sel;
            if ($urandom_range(0, 31) == 0) lz_en = ~lz_en;
            tick(nxt, ($urandom_range(0, 5) == 0), 16'($urandom), 4'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
